// File: rtl/ecg_frame_sequencer_if.sv
// ecg_frame_sequencer_if: RX, Data RAM, compute and TX signals
// shared by the frame sequencer and its neighbours.
interface ecg_frame_sequencer_if #(
    parameter int BIT_WIDTH = 16,
    parameter int AW_IN     = 9,
    parameter int AW_OUT    = 1
);
    logic                 Rx_valid;
    logic [BIT_WIDTH-1:0] Rx_data;
    logic                 Wr_en;
    logic [AW_IN-1:0]     Wr_addr;
    logic [BIT_WIDTH-1:0] Wr_data;
    logic                 Compute_Enable;
    logic                 Compute_Done;
    logic [AW_OUT-1:0]    Rd_addr;
    logic [BIT_WIDTH-1:0] Rd_data;
    logic                 Tx_start;
    logic [BIT_WIDTH-1:0] Tx_data;
    logic                 Tx_idle;

    modport master (
        input  Rx_valid,
        input  Rx_data,
        input  Compute_Done,
        input  Rd_data,
        input  Tx_idle,
        output Wr_en,
        output Wr_addr,
        output Wr_data,
        output Compute_Enable,
        output Rd_addr,
        output Tx_start,
        output Tx_data
    );

    modport slave (
        output Rx_valid,
        output Rx_data,
        output Compute_Done,
        output Rd_data,
        output Tx_idle,
        input  Wr_en,
        input  Wr_addr,
        input  Wr_data,
        input  Compute_Enable,
        input  Rd_addr,
        input  Tx_start,
        input  Tx_data
    );
endinterface

// File: rtl/ecg_frame_sequencer.sv
// ecg_frame_sequencer: collects an input frame into Data RAM, runs compute,
// then streams the result words to the UART TX flow controller.
module ecg_frame_sequencer #(
    parameter int BIT_WIDTH      = 16,
    parameter int N_IN           = 512,
    parameter int N_OUT          = 1,
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int AW_IN          = $clog2(N_IN),
    parameter int AW_OUT         = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    ecg_frame_sequencer_if.master bus,
    output logic [2:0]            State,
    output logic [15:0]           Frame_count,
    output logic [7:0]            Timeout_count,
    output logic                  Overrun
);
    localparam logic [2:0] S_RX       = 3'd0;
    localparam logic [2:0] S_COMPUTE  = 3'd1;
    localparam logic [2:0] S_TX_FETCH = 3'd2;
    localparam logic [2:0] S_TX_SEND  = 3'd3;
    localparam logic [2:0] S_TX_BUSY  = 3'd4;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]     T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW_IN-1:0]  IN_LAST  = AW_IN'(N_IN - 1);
    localparam logic [AW_OUT-1:0] OUT_LAST = AW_OUT'(N_OUT - 1);

    logic [2:0]           state;
    logic [AW_IN-1:0]     rx_cnt;
    logic [AW_OUT-1:0]    tx_cnt;
    logic [TW-1:0]        timer;
    logic                 guard;
    logic                 wr_en;
    logic [AW_IN-1:0]     wr_addr;
    logic [BIT_WIDTH-1:0] wr_data;
    logic                 comp_en;
    logic [AW_OUT-1:0]    rd_addr;
    logic                 tx_start;
    logic [BIT_WIDTH-1:0] tx_data;

    assign bus.Wr_en          = wr_en;
    assign bus.Wr_addr        = wr_addr;
    assign bus.Wr_data        = wr_data;
    assign bus.Compute_Enable = comp_en;
    assign bus.Rd_addr        = rd_addr;
    assign bus.Tx_start       = tx_start;
    assign bus.Tx_data        = tx_data;
    assign State              = state;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= S_RX;
            rx_cnt        <= '0;
            tx_cnt        <= '0;
            timer         <= '0;
            guard         <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            comp_en       <= 1'b0;
            rd_addr       <= '0;
            tx_start      <= 1'b0;
            tx_data       <= '0;
            Frame_count   <= '0;
            Timeout_count <= '0;
            Overrun       <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            tx_start <= 1'b0;
            if (bus.Rx_valid && state != S_RX)
                Overrun <= 1'b1;

            unique case (state)
                S_RX: begin
                    if (bus.Rx_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= rx_cnt;
                        wr_data <= bus.Rx_data;
                        timer   <= '0;
                        if (rx_cnt == IN_LAST) begin
                            rx_cnt  <= '0;
                            comp_en <= 1'b1;
                            state   <= S_COMPUTE;
                        end else begin
                            rx_cnt <= rx_cnt + AW_IN'(1);
                        end
                    end else if (rx_cnt != '0) begin
                        // partial frame idle too long: drop it
                        if (timer == T_LAST) begin
                            rx_cnt <= '0;
                            timer  <= '0;
                            if (Timeout_count != 8'hFF)
                                Timeout_count <= Timeout_count + 8'd1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (bus.Compute_Done) begin
                        comp_en <= 1'b0;
                        tx_cnt  <= '0;
                        rd_addr <= '0;
                        state   <= S_TX_FETCH;
                    end
                end
                S_TX_FETCH: begin
                    state <= S_TX_SEND;
                end
                S_TX_SEND: begin
                    if (bus.Tx_idle) begin
                        tx_data  <= bus.Rd_data;
                        tx_start <= 1'b1;
                        guard    <= 1'b1;
                        state    <= S_TX_BUSY;
                    end
                end
                S_TX_BUSY: begin
                    // UART may not drop Tx_idle until a cycle after Tx_start
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (bus.Tx_idle) begin
                        if (tx_cnt == OUT_LAST) begin
                            Frame_count <= Frame_count + 16'd1;
                            state       <= S_RX;
                        end else begin
                            tx_cnt  <= tx_cnt + AW_OUT'(1);
                            rd_addr <= tx_cnt + AW_OUT'(1);
                            state   <= S_TX_FETCH;
                        end
                    end
                end
                default: begin
                    state <= S_RX;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ecg_frame_sequencer.sv
// tb_ecg_frame_sequencer: directed scenarios with N_IN=4, N_OUT=2,
// TIMEOUT_CYCLES=10, small RAM and UART TX models.
module tb_ecg_frame_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        done;
    logic [15:0] rd_q;
    logic [2:0]  st;
    logic [15:0] fcnt;
    logic [7:0]  tcnt;
    logic        ovr;
    int          busy_cnt;
    logic        prev_ts;
    int          dbl_err;
    logic [15:0] cap [0:15];
    int          cap_n;
    int          pass_cnt;
    int          total_cnt;

    ecg_frame_sequencer_if #(.BIT_WIDTH(16), .AW_IN(2), .AW_OUT(1)) bus();

    ecg_frame_sequencer #(
        .BIT_WIDTH(16), .N_IN(4), .N_OUT(2), .TIMEOUT_CYCLES(10)
    ) dut (
        .Clk(clk),
        .Rst_n(rst_n),
        .bus(bus.master),
        .State(st),
        .Frame_count(fcnt),
        .Timeout_count(tcnt),
        .Overrun(ovr)
    );

    always #5 clk = ~clk;

    assign bus.Rx_valid     = rx_valid;
    assign bus.Rx_data      = rx_data;
    assign bus.Compute_Done = done;
    assign bus.Rd_data      = rd_q;
    assign bus.Tx_idle      = (busy_cnt == 0);

    always @(posedge clk)
        rd_q <= (bus.Rd_addr == 1'b0) ? 16'hA5A5 : 16'h5A5A;

    // UART TX model: busy for 3 cycles after each Tx_start
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 0;
        else if (bus.Tx_start) busy_cnt <= 3;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    initial begin
        cap_n   = 0;
        dbl_err = 0;
        prev_ts = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.Tx_start && prev_ts) dbl_err = dbl_err + 1;
        if (bus.Tx_start && cap_n < 16) begin
            cap[cap_n] = bus.Tx_data;
            cap_n = cap_n + 1;
        end
        prev_ts = bus.Tx_start;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (st == s) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        total_cnt++;
        if (st !== 3'd0) $display("FAIL reset_state: got %0d want 0", st);
        else pass_cnt++;
        total_cnt++;
        if ({bus.Wr_en, bus.Compute_Enable, bus.Tx_start} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000",
                     {bus.Wr_en, bus.Compute_Enable, bus.Tx_start});
        else pass_cnt++;
        total_cnt++;
        if ({fcnt, tcnt, ovr} !== 25'd0)
            $display("FAIL reset_status: got %0h want 0", {fcnt, tcnt, ovr});
        else pass_cnt++;
        total_cnt++;
        if ({bus.Wr_addr, bus.Wr_data, bus.Rd_addr, bus.Tx_data} !== 35'd0)
            $display("FAIL reset_buses: got %0h want 0",
                     {bus.Wr_addr, bus.Wr_data, bus.Rd_addr, bus.Tx_data});
        else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_frame_rx();
        logic [15:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            exp_d = 16'(17 * (i + 1));
            send_word(exp_d);
            total_cnt++;
            if (bus.Wr_en !== 1'b1 || bus.Wr_addr !== 2'(i) || bus.Wr_data !== exp_d)
                $display("FAIL rx_write%0d: got en=%b a=%0d d=%h want en=1 a=%0d d=%h",
                         i, bus.Wr_en, bus.Wr_addr, bus.Wr_data, i, exp_d);
            else pass_cnt++;
            total_cnt++;
            if (bus.Compute_Enable !== (i == 3) || st !== ((i == 3) ? 3'd1 : 3'd0))
                $display("FAIL rx_ce%0d: got ce=%b st=%0d", i, bus.Compute_Enable, st);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (bus.Wr_en !== 1'b0 || bus.Compute_Enable !== 1'b1)
            $display("FAIL rx_after: got en=%b ce=%b want en=0 ce=1",
                     bus.Wr_en, bus.Compute_Enable);
        else pass_cnt++;
    endtask

    task automatic test_compute_tx();
        int n0;
        bit ok;
        n0 = cap_n;
        step();
        pulse_done();
        total_cnt++;
        if (bus.Compute_Enable !== 1'b0 || st !== 3'd2)
            $display("FAIL done_resp: got ce=%b st=%0d want ce=0 st=2",
                     bus.Compute_Enable, st);
        else pass_cnt++;
        step();
        total_cnt++;
        if (st !== 3'd3 || bus.Tx_start !== 1'b0)
            $display("FAIL tx_send: got st=%0d ts=%b want st=3 ts=0", st, bus.Tx_start);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.Tx_start !== 1'b1 || bus.Tx_data !== 16'hA5A5 || st !== 3'd4)
            $display("FAIL tx_first: got ts=%b d=%h st=%0d want ts=1 d=a5a5 st=4",
                     bus.Tx_start, bus.Tx_data, st);
        else pass_cnt++;
        wait_state(3'd0, 60, ok);
        total_cnt++;
        if (!ok) $display("FAIL tx_finish: got st=%0d want 0 within bound", st);
        else pass_cnt++;
        total_cnt++;
        if (cap_n - n0 !== 2 || cap[n0] !== 16'hA5A5 || cap[n0 + 1] !== 16'h5A5A)
            $display("FAIL tx_words: got n=%0d %h %h want 2 a5a5 5a5a",
                     cap_n - n0, cap[n0], cap[n0 + 1]);
        else pass_cnt++;
        total_cnt++;
        if (fcnt !== 16'd1) $display("FAIL frame_cnt1: got %0d want 1", fcnt);
        else pass_cnt++;
        total_cnt++;
        if (dbl_err !== 0) $display("FAIL tx_double: got %0d want 0", dbl_err);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        send_word(16'h0001);
        send_word(16'h0002);
        repeat (9) step();
        total_cnt++;
        if (tcnt !== 8'd0) $display("FAIL to_early: got %0d want 0", tcnt);
        else pass_cnt++;
        step();
        total_cnt++;
        if (tcnt !== 8'd1) $display("FAIL to_fire: got %0d want 1", tcnt);
        else pass_cnt++;
        send_word(16'h0BEE);
        total_cnt++;
        if (bus.Wr_en !== 1'b1 || bus.Wr_addr !== 2'd0 || tcnt !== 8'd1)
            $display("FAIL to_restart: got en=%b a=%0d tc=%0d want 1 0 1",
                     bus.Wr_en, bus.Wr_addr, tcnt);
        else pass_cnt++;
        repeat (10) step();
        total_cnt++;
        if (tcnt !== 8'd2) $display("FAIL to_second: got %0d want 2", tcnt);
        else pass_cnt++;
    endtask

    task automatic test_timeout_race();
        send_word(16'h0003);
        send_word(16'h0004);
        repeat (9) step();
        send_word(16'h0005);
        total_cnt++;
        if (bus.Wr_addr !== 2'd2 || bus.Wr_data !== 16'h0005 || tcnt !== 8'd2)
            $display("FAIL race_word: got a=%0d d=%h tc=%0d want 2 0005 2",
                     bus.Wr_addr, bus.Wr_data, tcnt);
        else pass_cnt++;
        send_word(16'h0006);
        total_cnt++;
        if (bus.Wr_addr !== 2'd3 || st !== 3'd1 || bus.Compute_Enable !== 1'b1)
            $display("FAIL race_last: got a=%0d st=%0d ce=%b want 3 1 1",
                     bus.Wr_addr, st, bus.Compute_Enable);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        bit ok;
        total_cnt++;
        if (ovr !== 1'b0) $display("FAIL ovr_pre: got %b want 0", ovr);
        else pass_cnt++;
        send_word(16'hDEAD);
        total_cnt++;
        if (bus.Wr_en !== 1'b0 || ovr !== 1'b1 || st !== 3'd1)
            $display("FAIL ovr_set: got en=%b ovr=%b st=%0d want 0 1 1",
                     bus.Wr_en, ovr, st);
        else pass_cnt++;
        pulse_done();
        wait_state(3'd0, 60, ok);
        total_cnt++;
        if (!ok || fcnt !== 16'd2 || ovr !== 1'b1)
            $display("FAIL ovr_frame: got ok=%b fc=%0d ovr=%b want 1 2 1", ok, fcnt, ovr);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n0;
        for (int i = 0; i < 4; i++) send_word(16'(i + 8));
        pulse_done();
        wait_state(3'd4, 20, ok);
        total_cnt++;
        if (!ok) $display("FAIL mid_reach: got st=%0d want 4 within bound", st);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (st !== 3'd0 || bus.Tx_start !== 1'b0 || bus.Compute_Enable !== 1'b0)
            $display("FAIL mid_async: got st=%0d ts=%b ce=%b want 0 0 0",
                     st, bus.Tx_start, bus.Compute_Enable);
        else pass_cnt++;
        total_cnt++;
        if ({fcnt, tcnt, ovr} !== 25'd0 || {bus.Tx_data, bus.Rd_addr} !== 17'd0)
            $display("FAIL mid_clear: got %0h %0h want 0 0",
                     {fcnt, tcnt, ovr}, {bus.Tx_data, bus.Rd_addr});
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
        n0 = cap_n;
        send_word(16'h0100);
        total_cnt++;
        if (bus.Wr_addr !== 2'd0 || bus.Wr_en !== 1'b1)
            $display("FAIL post_first: got a=%0d en=%b want 0 1", bus.Wr_addr, bus.Wr_en);
        else pass_cnt++;
        for (int i = 1; i < 4; i++) send_word(16'(i + 256));
        pulse_done();
        wait_state(3'd0, 60, ok);
        total_cnt++;
        if (!ok || fcnt !== 16'd1 || cap_n - n0 !== 2 || cap[n0 + 1] !== 16'h5A5A)
            $display("FAIL post_frame: got ok=%b fc=%0d n=%0d w1=%h want 1 1 2 5a5a",
                     ok, fcnt, cap_n - n0, cap[n0 + 1]);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        done      = 1'b0;
        step();
        test_reset();
        test_frame_rx();
        test_compute_tx();
        test_timeout();
        test_timeout_race();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule

// File: doc/ecg_frame_sequencer.md
# ecg_frame_sequencer

Parametrised top-level sequencer for the ECG inference pipeline. It collects an N_IN-word input frame from the UART RX flow controller into Data RAM, runs the compute processor, then streams N_OUT result words from Data RAM to the UART TX flow controller. Partial frames are discarded on an inter-word timeout. Status outputs expose frame and error counts. It sits between the UART flow controllers, Data RAM and Compute_Processor, and replaces the fixed 512-in/1-out sequencing.

## Interface
- BIT_WIDTH, 16, data word width
- N_IN, 512, input words per frame (≥2)
- N_OUT, 1, output words per frame (≥1)
- TIMEOUT_CYCLES, 250000, idle cycles inside a partial frame before it is discarded
- AW_IN, $clog2(N_IN), write-address width
- AW_OUT, max(1,$clog2(N_OUT)), read-address width

- Clk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- Rx_valid  in  1  one-cycle strobe: Rx_data holds a new word
- Rx_data  in  BIT_WIDTH  received word
- Wr_en  out  1  Data RAM write strobe
- Wr_addr  out  AW_IN  Data RAM write address
- Wr_data  out  BIT_WIDTH  Data RAM write data
- Compute_Enable  out  1  level; high while compute runs
- Compute_Done  in  1  compute finished (level or pulse)
- Rd_addr  out  AW_OUT  result read address
- Rd_data  in  BIT_WIDTH  RAM read data, valid 1 cycle after Rd_addr
- Tx_start  out  1  one-cycle send strobe to UART TX
- Tx_data  out  BIT_WIDTH  word to send, stable from Tx_start until next Tx_start
- Tx_idle  in  1  UART TX ready
- State  out  3  current state encoding
- Frame_count  out  16  completed frames, wraps
- Timeout_count  out  8  discarded partial frames, saturates at 255
- Overrun  out  1  sticky: Rx_valid seen outside RX

## Operation
- States: RX=0, COMPUTE=1, TX_FETCH=2, TX_SEND=3, TX_BUSY=4. Reset → RX.
- Reset values: all outputs 0; rx_cnt, tx_cnt, timer 0.
- RX: Rx_valid → next cycle Wr_en=1, Wr_addr=rx_cnt, Wr_data=Rx_data; rx_cnt++; timer←0. If the word was index N_IN-1 → COMPUTE, rx_cnt←0. Otherwise Wr_en=0.
- Timeout: timer increments only while in RX with rx_cnt≠0 and no Rx_valid. When timer reaches TIMEOUT_CYCLES-1: rx_cnt←0, timer←0, Timeout_count++ (saturating). A Rx_valid in the same cycle wins; no timeout occurs.
- COMPUTE: Compute_Enable=1 from the first COMPUTE cycle. Compute_Done sampled high → Compute_Enable←0, tx_cnt←0, Rd_addr←0, → TX_FETCH.
- TX_FETCH: one cycle for RAM latency → TX_SEND.
- TX_SEND: wait for Tx_idle=1. Then Tx_data←Rd_data, Tx_start=1 for one cycle, → TX_BUSY.
- TX_BUSY: ignore Tx_idle on the first cycle (guard). Afterwards, on Tx_idle=1: if tx_cnt==N_OUT-1, Frame_count++ and → RX. Otherwise tx_cnt++, Rd_addr←tx_cnt+1, → TX_FETCH.
- Rx_valid in any state other than RX: the word is dropped and Overrun←1 (cleared only by reset).
- Rst_n low mid-operation: immediate return to reset values. The partial frame is lost and Compute_Enable drops asynchronously.

## Timing
- Rx_valid at cycle t → Wr_en at t+1. After the last input word: State=COMPUTE and Compute_Enable=1 at t+1.
- Compute_Done at t → Compute_Enable=0 and State=TX_FETCH at t+1, earliest Tx_start at t+3.
- Per output word, minimum 3 cycles plus UART busy time. Tx_start is never asserted twice without an intervening TX_BUSY.
- Back-to-back Rx_valid every cycle is accepted with no loss.

## Test plan
- N_IN=4, N_OUT=2: send 4 words 0x0011..0x0044 → Wr_en at addr 0..3 with matching data; Compute_Enable rises 1 cycle after the 4th word.
- Compute_Done pulse; RAM model returns 0xA5A5 and 0x5A5A → two Tx_start pulses with those Tx_data values in order; Frame_count=1; State=RX.
- TIMEOUT_CYCLES=10: send 2 words then idle 10 cycles → Timeout_count=1, next word written at addr 0.
- Rx_valid exactly on the cycle the timeout would fire → word written at addr 2, Timeout_count unchanged.
- Rx_valid during COMPUTE → Overrun=1, no Wr_en; after reset Overrun=0.
- Assert Rst_n=0 in TX_BUSY → all outputs 0 and State=RX immediately; a full frame afterwards completes with Frame_count=1.
